// File: rtl/reg_bank_reader_pkg.sv
// Shared constants for the register bank reader: FSM state encoding and
// default geometry of the 8 x 32-bit bank it drains.
// Ports: none (package).
package reg_bank_reader_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 8;
  localparam int IDX_W    = 3;

  // Two-state scan FSM; encoding kept as plain constants so older
  // tooling that compares raw state bits keeps working.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/reg_pri_enc8.sv
// Purpose: lowest-set-bit priority encoder over an 8-bit select vector.
// Latency: combinational, zero cycles.
// Backpressure: none (pure logic).
// Ports: vec (in, 8) - candidate bits; idx (out, 3) - lowest set index;
//        any_set (out) - vec != 0; multi_set (out) - two or more bits set.
module reg_pri_enc8
  import reg_bank_reader_pkg::*;
(
  input  logic [NUM_REGS-1:0] vec,
  output logic [IDX_W-1:0]    idx,
  output logic                any_set,
  output logic                multi_set
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (vec[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  assign any_set   = |vec;
  // Clearing the lowest set bit leaves something only if another bit was set.
  assign multi_set = |(vec & (vec - NUM_REGS'(1)));

endmodule

// File: rtl/reg_bank_reader.sv
// Purpose: on start, stream the masked bank registers lowest index first.
// Latency: first word valid one edge after start; one word per cycle after.
// Backpressure: word held stable while out_valid=1 and out_ready=0.
// Ports: clk, clear (async active-high reset), start/mask (scan request),
//        d_in0..d_in7 (live bank contents), out_valid/out_ready/out_data/
//        out_idx/out_last (word stream), busy (scan active), done (end pulse).
module reg_bank_reader
  import reg_bank_reader_pkg::*;
(
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic [NUM_REGS-1:0] mask,
  input  logic [DATA_W-1:0]   d_in0,
  input  logic [DATA_W-1:0]   d_in1,
  input  logic [DATA_W-1:0]   d_in2,
  input  logic [DATA_W-1:0]   d_in3,
  input  logic [DATA_W-1:0]   d_in4,
  input  logic [DATA_W-1:0]   d_in5,
  input  logic [DATA_W-1:0]   d_in6,
  input  logic [DATA_W-1:0]   d_in7,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  logic [0:0]          state;
  // Bits still to be loaded; the word currently presented is already removed.
  logic [NUM_REGS-1:0] pending;

  logic [NUM_REGS-1:0] enc_in;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_any;
  logic                sel_multi;
  logic [NUM_REGS-1:0] sel_bit;
  logic [NUM_REGS-1:0] remaining;
  logic [DATA_W-1:0]   sel_word;

  // In IDLE the encoder looks at the incoming mask, in SEND at what is left.
  assign enc_in = (state == ST_IDLE) ? mask : pending;

  reg_pri_enc8 u_pri_enc (
    .vec       (enc_in),
    .idx       (sel_idx),
    .any_set   (sel_any),
    .multi_set (sel_multi)
  );

  assign sel_bit   = NUM_REGS'(1) << sel_idx;
  assign remaining = enc_in & ~sel_bit;

  always_comb begin
    sel_word = '0;
    case (sel_idx)
      3'd0:    sel_word = d_in0;
      3'd1:    sel_word = d_in1;
      3'd2:    sel_word = d_in2;
      3'd3:    sel_word = d_in3;
      3'd4:    sel_word = d_in4;
      3'd5:    sel_word = d_in5;
      3'd6:    sel_word = d_in6;
      default: sel_word = d_in7;
    endcase
  end

  // The stream is valid exactly while a scan is in SEND.
  assign out_valid = (state == ST_SEND);
  assign busy      = (state == ST_SEND);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= ST_IDLE;
      pending  <= '0;
      out_data <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (sel_any) begin
              // Snapshot the selected register now; later bank writes
              // must not disturb the presented word.
              pending  <= remaining;
              out_data <= sel_word;
              out_idx  <= sel_idx;
              out_last <= !sel_multi;
              state    <= ST_SEND;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (sel_any) begin
              pending  <= remaining;
              out_data <= sel_word;
              out_idx  <= sel_idx;
              out_last <= !sel_multi;
            end else begin
              pending  <= '0;
              out_data <= '0;
              out_idx  <= '0;
              out_last <= 1'b0;
              done     <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Purpose: scoreboard bench for reg_bank_reader; expected words queued by
// stimulus, popped and compared by a negedge monitor on each transfer.
// Ports: none (top-level bench).
module tb_reg_bank_reader;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        clear;
  logic        start;
  logic [7:0]  mask;
  logic [31:0] d_reg [8];
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   done_cnt;
  logic prev_done;

  reg_bank_reader dut (
    .clk       (clk),
    .clear     (clear),
    .start     (start),
    .mask      (mask),
    .d_in0     (d_reg[0]),
    .d_in1     (d_reg[1]),
    .d_in2     (d_reg[2]),
    .d_in3     (d_reg[3]),
    .d_in4     (d_reg[4]),
    .d_in5     (d_reg[5]),
    .d_in6     (d_reg[6]),
    .d_in7     (d_reg[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int i, input logic last);
    exp_t e;
    e.idx  = 3'(i);
    e.data = d_reg[i];
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!clear) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got idx %0d data %h, required no word", out_idx, out_data);
          end else begin
            e = sb[0];
            chk("mon_idx", 32'(out_idx), 32'(e.idx));
            chk("mon_data", out_data, e.data);
            chk("mon_last", 32'(out_last), 32'(e.last));
            if (out_ready) void'(sb.pop_front());
          end
        end else begin
          chk("idle_outputs_zero", out_data | 32'(out_idx) | 32'(out_last), 32'h0);
        end
        if (done) begin
          done_cnt++;
          chk("done_one_cycle", 32'(prev_done), 32'h0);
        end
        prev_done = done;
      end else begin
        prev_done = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one sampling edge; returns at edge+1.
  task automatic do_start(input logic [7:0] m);
    start = 1'b1;
    mask  = m;
    cyc();
    start = 1'b0;
    mask  = 8'h00;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      cyc();
      n++;
    end
    chk(name, 32'(done), 32'h1);
  endtask

  initial begin
    int dc;
    checks    = 0;
    errors    = 0;
    done_cnt  = 0;
    prev_done = 1'b0;
    clear     = 1'b1;
    start     = 1'b0;
    mask      = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) d_reg[i] = 32'hC0DE_0000 + 32'(i) * 32'h0101;
    fork
      monitor();
    join_none

    // Reset asserted before any clock edge: outputs already zero.
    #2;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_idx_last", 32'(out_idx) | 32'(out_last), 32'h0);
    cyc();
    clear = 1'b0;
    cyc();

    // Full mask, ready high: eight back-to-back words.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(i, i == 7);
    do_start(8'hFF);
    for (int i = 0; i < 8; i++) begin
      chk("full_valid", 32'(out_valid), 32'h1);
      chk("full_idx", 32'(out_idx), 32'(i));
      cyc();
    end
    chk("full_done", 32'(done), 32'h1);
    chk("full_busy_after", 32'(busy), 32'h0);
    cyc();
    chk("full_done_drop", 32'(done), 32'h0);
    chk("full_sb_empty", 32'(sb.size()), 32'h0);

    // Sparse mask with alternating ready.
    out_ready = 1'b0;
    push(2, 1'b0);
    push(5, 1'b0);
    push(7, 1'b1);
    dc = done_cnt;
    do_start(8'b1010_0100);
    for (int n = 0; n < 30 && !done; n++) begin
      out_ready = ~out_ready;
      cyc();
    end
    chk("sparse_done", 32'(done), 32'h1);
    out_ready = 1'b0;
    cyc();
    chk("sparse_sb_empty", 32'(sb.size()), 32'h0);
    chk("sparse_done_count", 32'(done_cnt - dc), 32'h1);

    // Snapshot: bank write while a word is stalled.
    out_ready = 1'b0;
    push(2, 1'b1);
    do_start(8'h04);
    chk("snap_valid", 32'(out_valid), 32'h1);
    d_reg[2] = 32'hDEAD_BEEF;
    cyc();
    cyc();
    chk("snap_held", out_data, 32'hC0DE_0202);
    out_ready = 1'b1;
    cyc();
    chk("snap_valid_drop", 32'(out_valid), 32'h0);
    chk("snap_done", 32'(done), 32'h1);
    d_reg[2] = 32'hC0DE_0202;
    cyc();

    // Empty mask: done only, no word, never busy.
    do_start(8'h00);
    chk("empty_done", 32'(done), 32'h1);
    chk("empty_busy", 32'(busy), 32'h0);
    chk("empty_valid", 32'(out_valid), 32'h0);
    cyc();
    chk("empty_done_drop", 32'(done), 32'h0);

    // Start while busy is ignored; start in the done cycle is accepted.
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) push(i, i == 7);
    do_start(8'hF0);
    chk("busy_first_idx", 32'(out_idx), 32'h4);
    do_start(8'h01);
    wait_done("busy_scan_done");
    push(1, 1'b1);
    do_start(8'h02);
    chk("done_cycle_start_valid", 32'(out_valid), 32'h1);
    chk("done_cycle_start_idx", 32'(out_idx), 32'h1);
    chk("done_cycle_start_busy", 32'(busy), 32'h1);
    wait_done("done_cycle_scan_done");
    cyc();
    chk("busy_sb_empty", 32'(sb.size()), 32'h0);

    // Clear mid-stream while idx 3 is presented.
    for (int i = 0; i < 8; i++) push(i, i == 7);
    do_start(8'hFF);
    for (int n = 0; n < 20 && !(out_valid && out_idx == 3'd3); n++) cyc();
    out_ready = 1'b0;
    chk("reach_idx3", 32'(out_idx), 32'h3);
    #2;
    clear = 1'b1;
    #1;
    chk("clr_valid", 32'(out_valid), 32'h0);
    chk("clr_data", out_data, 32'h0);
    chk("clr_idx_last", 32'(out_idx) | 32'(out_last), 32'h0);
    chk("clr_busy_done", 32'(busy) | 32'(done), 32'h0);
    sb.delete();
    cyc();
    clear     = 1'b0;
    out_ready = 1'b1;
    cyc();
    push(7, 1'b1);
    do_start(8'h80);
    chk("post_clr_idx", 32'(out_idx), 32'h7);
    chk("post_clr_last", 32'(out_last), 32'h1);
    cyc();
    chk("post_clr_done", 32'(done), 32'h1);
    cyc();
    chk("final_sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
